if_fetch_buffer: RTL and testbench
==================================

Name: if_fetch_buffer

Overview:
Instruction-fetch stage directly downstream of the PC register. It takes the current PC and issues a word read on the instruction-memory request/grant/response bus. Returned instructions are buffered with their PC in a small FIFO and presented to decode over a valid/ready handshake. The block back-pressures the PC register, and on a jump it flushes all buffered and in-flight instructions.

Parameters:
CPU_WIDTH, 32, data/address width (matches CpuWidth in define.v)
DEPTH, 2, instruction FIFO entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
pc_i  in  CPU_WIDTH  fetch address from PC register
jump_en_i  in  1  redirect/flush; same signal that loads the PC register
pc_stall_o  out  1  hold request to PC register; PC must not advance while 1
imem_req_o  out  1  memory request valid
imem_addr_o  out  CPU_WIDTH  request address, word aligned
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response data valid
imem_rdata_i  in  CPU_WIDTH  response instruction
inst_valid_o  out  1  FIFO head valid to decode
inst_o  out  CPU_WIDTH  head instruction
inst_pc_o  out  CPU_WIDTH  head PC
inst_ready_i  in  1  decode accepts head

Behaviour:
- Reset is clk_i / rstn_i, asynchronous, active-low. All state clears on reset. Reset values: state=IDLE, FIFO empty, inst_valid_o=0, inst_o=0, inst_pc_o=0, imem_req_o=0, imem_addr_o=0, pc_stall_o=1.
- At most one transaction is outstanding. FSM:
  - IDLE -> REQ when the FIFO has a free slot. The count includes the slot reserved for the outstanding fetch, so REQ is entered only if count+reserved < DEPTH.
  - REQ: imem_req_o=1. imem_addr_o = pc_i with bits [1:0] forced to 0, captured into req_pc on entry and held stable until grant. On imem_gnt_i -> WAIT.
  - WAIT: on imem_rvalid_i, push {req_pc, imem_rdata_i}. Then go to REQ if space remains, else IDLE.
- pc_stall_o = 0 only in the cycle imem_gnt_i is high in REQ. The PC therefore advances exactly once per granted fetch.
- Latency: with gnt and rvalid both returned next-cycle, an instruction appears on inst_valid_o 1 cycle after rvalid (registered FIFO output).
- FIFO: push on rvalid, pop when inst_valid_o && inst_ready_i. Simultaneous push and pop when full is legal; count is unchanged. Pointers wrap modulo DEPTH. inst_o and inst_pc_o hold their value while valid && !ready.
- Flush (jump_en_i=1):
  - FIFO is emptied next cycle.
  - In REQ before grant: drop the request and re-enter REQ with the new pc_i on the following cycle.
  - In WAIT: set discard flag. The next rvalid is dropped and not pushed, then go to REQ.
  - A flush coinciding with rvalid drops that response.
  - A flush coinciding with gnt: the transaction is discarded in the same way.
- rvalid outside WAIT is ignored.
- A reset mid-transaction abandons it, and any late rvalid after reset is ignored (state is IDLE).

Decomposition:
- Shared package/define.v: CpuWidth, instruction NOP constant (32'h00000013), FSM state encodings IF_IDLE/IF_REQ/IF_WAIT.
- One sub-module, if_inst_fifo: a parameterised synchronous FIFO holding {pc, inst}, with flush, push, pop, full, empty and count.

Test Plan:
- Back-to-back fetch: gnt=1 and rvalid the next cycle, ready=1, pc 0x0,0x4,0x8 -> inst_pc_o sequence 0x0,0x4,0x8 with matching rdata. pc_stall_o low one cycle per grant.
- Grant delay: gnt withheld for 3 cycles -> imem_req_o held high, imem_addr_o stable at 0x10, pc_stall_o=1 throughout.
- Backpressure: ready=0 -> after 2 pushes the FIFO is full, imem_req_o=0, pc_stall_o=1. Raising ready resumes with the head at 0x0.
- Flush in WAIT: jump_en_i at pc=0x100 while fetch 0x8 is outstanding -> rdata for 0x8 discarded, FIFO empty, next request address 0x100.
- Flush together with pop and rvalid in the same cycle -> nothing pushed, inst_valid_o=0 next cycle.
- Reset asserted mid-WAIT, then rvalid arrives -> all outputs at reset values, no push.

Source files
------------

// File: rtl/if_fetch_buffer_pkg.sv
// Shared definitions for the instruction-fetch stage: data width, NOP encoding
// and the fetch FSM state encoding.
package if_fetch_buffer_pkg;

    localparam int CpuWidth = 32;
    localparam logic [31:0] InstNop = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous FIFO holding {pc, inst} entries. The head is read straight from
// storage, so a pushed entry is visible the cycle after the push.
module if_inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction fetch: one outstanding req/gnt/rvalid transaction, responses
// buffered with their PC and handed to decode over valid/ready.
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter int CPU_WIDTH = CpuWidth,
    parameter int DEPTH     = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [CPU_WIDTH-1:0] pc_i,
    input  logic                 jump_en_i,
    output logic                 pc_stall_o,
    output logic                 imem_req_o,
    output logic [CPU_WIDTH-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [CPU_WIDTH-1:0] imem_rdata_i,
    output logic                 inst_valid_o,
    output logic [CPU_WIDTH-1:0] inst_o,
    output logic [CPU_WIDTH-1:0] inst_pc_o,
    input  logic                 inst_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CPU_WIDTH-1:0] AlignMask = ~CPU_WIDTH'(3);

    if_state_e              state_q, state_d;
    logic [CPU_WIDTH-1:0]   req_pc_q, req_pc_d;
    logic                   discard_q, discard_d;

    logic [CPU_WIDTH-1:0]   pc_aligned;
    logic                   granted;
    logic                   resp;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [2*CPU_WIDTH-1:0] fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          count_after;
    logic                   has_space;

    assign pc_aligned = pc_i & AlignMask;
    assign granted    = (state_q == IF_REQ) && imem_gnt_i;
    assign resp       = (state_q == IF_WAIT) && imem_rvalid_i;

    // A response is kept only if no flush has happened since its request was granted.
    assign fifo_push   = resp && !discard_q && !jump_en_i;
    assign fifo_pop    = inst_valid_o && inst_ready_i;
    assign count_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    assign has_space   = (count_after < CW'(DEPTH));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IF_IDLE;
            req_pc_q  <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_pc_d  = req_pc_q;
        discard_d = discard_q;
        case (state_q)
            IF_IDLE: begin
                if (!jump_en_i && !fifo_full) begin
                    state_d = IF_REQ;
                end
            end
            IF_REQ: begin
                // pc_i is frozen by pc_stall_o until this cycle, so it tags the response.
                if (imem_gnt_i) begin
                    state_d   = IF_WAIT;
                    req_pc_d  = pc_aligned;
                    discard_d = jump_en_i;
                end
            end
            IF_WAIT: begin
                if (imem_rvalid_i) begin
                    discard_d = 1'b0;
                    state_d   = (jump_en_i || discard_q || has_space) ? IF_REQ : IF_IDLE;
                end else if (jump_en_i) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = '0;
        pc_stall_o  = 1'b1;
        if (state_q == IF_REQ) begin
            imem_req_o  = 1'b1;
            imem_addr_o = pc_aligned;
            pc_stall_o  = !granted;
        end
    end

    if_inst_fifo #(
        .WIDTH (2 * CPU_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (jump_en_i),
        .push_i  (fifo_push),
        .wdata_i ({req_pc_q, imem_rdata_i}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign inst_valid_o = !fifo_empty;
    assign inst_pc_o    = inst_valid_o ? fifo_rdata[2*CPU_WIDTH-1:CPU_WIDTH] : '0;
    assign inst_o       = inst_valid_o ? fifo_rdata[CPU_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer: per-cycle vector table plus a reset
// sequence, with an in-order queue of instructions decode should receive.
module tb_if_fetch_buffer;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [31:0] pc_i;
    logic        jump_en_i;
    logic        pc_stall_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] pc;
        logic        jump;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
    } vec_t;

    localparam int NV = 36;
    vec_t vecs[NV];

    localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h1111_0001, A2 = 32'h1111_0002;
    localparam logic [31:0] A3 = 32'h1111_0003, A4 = 32'h1111_0004, A5 = 32'h1111_0005;
    localparam logic [31:0] B0 = 32'h2222_0000, B1 = 32'h2222_0001, C0 = 32'h3333_0000;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF, BADR = 32'hBAD0_BAD0;

    if_fetch_buffer #(.CPU_WIDTH(32), .DEPTH(2)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .pc_i          (pc_i),
        .jump_en_i     (jump_en_i),
        .pc_stall_o    (pc_stall_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(logic [31:0] pc, logic jump, logic gnt, logic rv,
                                logic [31:0] rdata, logic ready, logic e_req,
                                logic [31:0] e_addr, logic e_stall, logic e_valid,
                                logic [31:0] e_inst, logic [31:0] e_ipc);
        vec_t v;
        v.pc = pc; v.jump = jump; v.gnt = gnt; v.rvalid = rv; v.rdata = rdata;
        v.ready = ready; v.e_req = e_req; v.e_addr = e_addr; v.e_stall = e_stall;
        v.e_valid = e_valid; v.e_inst = e_inst; v.e_ipc = e_ipc;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        pc_i          = v.pc;
        jump_en_i     = v.jump;
        imem_gnt_i    = v.gnt;
        imem_rvalid_i = v.rvalid;
        imem_rdata_i  = v.rdata;
        inst_ready_i  = v.ready;
    endtask

    task automatic chk_outs(string tag, int idx, logic req, logic [31:0] addr,
                            logic stall, logic valid, logic [31:0] inst, logic [31:0] ipc);
        chk({tag, "_req"},   idx, 32'(imem_req_o),   32'(req));
        chk({tag, "_addr"},  idx, imem_addr_o,       addr);
        chk({tag, "_stall"}, idx, 32'(pc_stall_o),   32'(stall));
        chk({tag, "_valid"}, idx, 32'(inst_valid_o), 32'(valid));
        chk({tag, "_inst"},  idx, inst_o,            inst);
        chk({tag, "_ipc"},   idx, inst_pc_o,         ipc);
    endtask

    // Every handshake with decode must deliver the next expected instruction.
    task automatic sb_check(int idx);
        if (inst_valid_o && inst_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra step=%0d got=%h want=none", idx, inst_o);
            end else begin
                chk("sb_inst", idx, inst_o, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        //            pc      j  g  rv rdata rdy  req addr    stl val inst ipc
        vecs[0]  = mk(32'h0,   0, 0, 0, 0,    1,  0, 32'h0,   1, 0, 0,  32'h0);
        vecs[1]  = mk(32'h0,   0, 1, 0, 0,    1,  1, 32'h0,   0, 0, 0,  32'h0);
        vecs[2]  = mk(32'h4,   0, 0, 1, A0,   1,  0, 32'h0,   1, 0, 0,  32'h0);
        vecs[3]  = mk(32'h4,   0, 1, 0, 0,    1,  1, 32'h4,   0, 1, A0, 32'h0);
        vecs[4]  = mk(32'h8,   0, 0, 1, A1,   1,  0, 32'h0,   1, 0, 0,  32'h0);
        vecs[5]  = mk(32'h8,   0, 1, 0, 0,    1,  1, 32'h8,   0, 1, A1, 32'h4);
        vecs[6]  = mk(32'hC,   0, 0, 1, A2,   1,  0, 32'h0,   1, 0, 0,  32'h0);
        vecs[7]  = mk(32'hC,   0, 1, 0, 0,    1,  1, 32'hC,   0, 1, A2, 32'h8);
        vecs[8]  = mk(32'h10,  0, 0, 1, A3,   1,  0, 32'h0,   1, 0, 0,  32'h0);
        vecs[9]  = mk(32'h10,  0, 0, 0, 0,    1,  1, 32'h10,  1, 1, A3, 32'hC);
        vecs[10] = mk(32'h10,  0, 0, 0, 0,    1,  1, 32'h10,  1, 0, 0,  32'h0);
        vecs[11] = mk(32'h10,  0, 0, 0, 0,    1,  1, 32'h10,  1, 0, 0,  32'h0);
        vecs[12] = mk(32'h10,  0, 1, 0, 0,    1,  1, 32'h10,  0, 0, 0,  32'h0);
        vecs[13] = mk(32'h14,  0, 0, 1, A4,   0,  0, 32'h0,   1, 0, 0,  32'h0);
        vecs[14] = mk(32'h14,  0, 1, 0, 0,    0,  1, 32'h14,  0, 1, A4, 32'h10);
        vecs[15] = mk(32'h18,  0, 0, 1, A5,   0,  0, 32'h0,   1, 1, A4, 32'h10);
        vecs[16] = mk(32'h18,  0, 0, 0, 0,    0,  0, 32'h0,   1, 1, A4, 32'h10);
        vecs[17] = mk(32'h18,  0, 0, 0, 0,    0,  0, 32'h0,   1, 1, A4, 32'h10);
        vecs[18] = mk(32'h18,  0, 0, 0, 0,    1,  0, 32'h0,   1, 1, A4, 32'h10);
        vecs[19] = mk(32'h18,  0, 0, 0, 0,    1,  0, 32'h0,   1, 1, A5, 32'h14);
        vecs[20] = mk(32'h18,  0, 1, 0, 0,    1,  1, 32'h18,  0, 0, 0,  32'h0);
        vecs[21] = mk(32'h1C,  1, 0, 0, 0,    1,  0, 32'h0,   1, 0, 0,  32'h0);
        vecs[22] = mk(32'h100, 0, 0, 1, DEAD, 1,  0, 32'h0,   1, 0, 0,  32'h0);
        vecs[23] = mk(32'h100, 0, 0, 0, 0,    1,  1, 32'h100, 1, 0, 0,  32'h0);
        vecs[24] = mk(32'h100, 0, 1, 0, 0,    1,  1, 32'h100, 0, 0, 0,  32'h0);
        vecs[25] = mk(32'h104, 0, 0, 1, B0,   1,  0, 32'h0,   1, 0, 0,  32'h0);
        vecs[26] = mk(32'h104, 0, 1, 0, 0,    0,  1, 32'h104, 0, 1, B0, 32'h100);
        vecs[27] = mk(32'h108, 1, 0, 1, B1,   1,  0, 32'h0,   1, 1, B0, 32'h100);
        vecs[28] = mk(32'h200, 0, 0, 0, 0,    1,  1, 32'h200, 1, 0, 0,  32'h0);
        vecs[29] = mk(32'h200, 0, 1, 0, 0,    1,  1, 32'h200, 0, 0, 0,  32'h0);
        vecs[30] = mk(32'h204, 0, 0, 1, C0,   1,  0, 32'h0,   1, 0, 0,  32'h0);
        vecs[31] = mk(32'h204, 1, 0, 0, 0,    0,  1, 32'h204, 1, 1, C0, 32'h200);
        vecs[32] = mk(32'h300, 1, 1, 0, 0,    0,  1, 32'h300, 0, 0, 0,  32'h0);
        vecs[33] = mk(32'h400, 0, 0, 1, BADR, 0,  0, 32'h0,   1, 0, 0,  32'h0);
        vecs[34] = mk(32'h400, 0, 1, 0, 0,    1,  1, 32'h400, 0, 0, 0,  32'h0);
        vecs[35] = mk(32'h404, 0, 0, 0, 0,    1,  0, 32'h0,   1, 0, 0,  32'h0);

        exp_q = '{A0, A1, A2, A3, A4, A5, B0};

        rstn_i = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk_i);
        #1;
        chk_outs("rst", 0, 0, 32'h0, 1, 0, 32'h0, 32'h0);
        rstn_i = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #2;
            chk_outs("vec", i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_stall,
                     vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_ipc);
            sb_check(i);
            @(posedge clk_i);
            #1;
        end

        // Reset in the middle of an outstanding fetch, with a late response.
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        #2;
        rstn_i = 1'b0;
        #1;
        chk_outs("midrst", 0, 0, 32'h0, 1, 0, 32'h0, 32'h0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hEEEE_EEEE;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        pc_i   = 32'h503;
        #2;
        chk_outs("postrst", 0, 0, 32'h0, 1, 0, 32'h0, 32'h0);
        @(posedge clk_i);
        #3;
        chk_outs("postrst", 1, 1, 32'h500, 1, 0, 32'h0, 32'h0);
        imem_rvalid_i = 1'b0;
        @(posedge clk_i);
        #3;
        chk_outs("postrst", 2, 1, 32'h500, 1, 0, 32'h0, 32'h0);

        chk("sb_left", 0, 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
